fnd_scan_driver: RTL and testbench

//   Consumes a 4-digit hex/BCD value and drives a common-anode 4-digit 7-segment (FND) display by time-multiplexing.

---
 rtl/fnd_pkg.sv | 10 +
 rtl/bcd_to_seg.sv | 9 +
 rtl/fnd_scan_driver.sv | 97 +++++++++
 tb/tb_fnd_scan_driver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared segment table, idle patterns and scan FSM states for the FND scan driver
package fnd_pkg;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [3:0] COM_OFF = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: 4-bit hex digit to active-high gfedcba segment pattern
module bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[val_i];
endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: 4-digit common-anode 7-seg scanner with blank gap and frame-aligned updates (optional FND_LZB_EN leading-zero blanking)
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data,
  output logic        frame_tick
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] SCAN_END  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC == 0 ? 0 : BLANK_CYC - 1);
  logic [PW-1:0] presc_q, presc_d;
  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d, pend_q, pend_d;
  logic [3:0]    shdp_q, shdp_d, pdp_q, pdp_d;
  logic          pending_q, pending_d;
  logic [3:0]    com_q, com_d, lzb;
  logic [7:0]    data_q, data_d;
  logic          tick_q, tick_d;
  logic          slot_end, boundary, drive;
  logic [3:0]    digit;
  logic [6:0]    seg;
  bcd_to_seg u_dec (.val_i(digit), .seg_o(seg));
  assign fnd_com    = com_q;
  assign fnd_data   = data_q;
  assign frame_tick = tick_q;
  // prescaler, scan FSM and digit index advance
  always_comb begin
    slot_end = presc_q == SCAN_END;
    presc_d  = slot_end ? '0 : presc_q + 1'b1;
    state_d  = state_q == ST_BLANK ? ((BLANK_CYC == 0 || presc_q == BLANK_END) ? ST_DRIVE : ST_BLANK)
                                   : (slot_end ? ST_BLANK : ST_DRIVE);
    idx_d    = (state_q == ST_DRIVE && slot_end) ? idx_q + 2'd1 : idx_q;
    boundary = state_q == ST_DRIVE && slot_end && idx_q == 2'd3;
  end
  // pending value is promoted to the shadow only at the frame boundary; a same-cycle load stays pending
  always_comb begin
    shadow_d  = (boundary && pending_q) ? pend_q : shadow_q;
    shdp_d    = (boundary && pending_q) ? pdp_q : shdp_q;
    pend_d    = load ? digits_in : pend_q;
    pdp_d     = load ? dp_in : pdp_q;
    pending_d = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
  end
  // registered pin drive from the current state and index
  always_comb begin
    digit = shadow_q[{idx_q, 2'b00} +: 4];
`ifdef FND_LZB_EN
    lzb[3] = shadow_q[15:12] == 4'd0 && !shdp_q[3];
    lzb[2] = shadow_q[15:8] == 8'd0 && !shdp_q[2];
    lzb[1] = shadow_q[15:4] == 12'd0 && !shdp_q[1];
    lzb[0] = 1'b0;
`else
    lzb = '0;
`endif
    drive  = state_q == ST_DRIVE;
    com_d  = drive ? ~(4'b0001 << idx_q) : COM_OFF;
    data_d = (drive && !lzb[idx_q]) ? ~{shdp_q[idx_q], seg} : SEG_OFF;
    tick_d = boundary;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q   <= '0;
      state_q   <= ST_BLANK;
      idx_q     <= '0;
      shadow_q  <= '0;
      shdp_q    <= '0;
      pend_q    <= '0;
      pdp_q     <= '0;
      pending_q <= 1'b0;
      com_q     <= COM_OFF;
      data_q    <= SEG_OFF;
      tick_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      shdp_q    <= shdp_d;
      pend_q    <= pend_d;
      pdp_q     <= pdp_d;
      pending_q <= pending_d;
      com_q     <= com_d;
      data_q    <= data_d;
      tick_q    <= tick_d;
    end
  end
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed stimulus with a frame-level display model compared every cycle
module tb_fnd_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        frame_tick;
  int compared = 0;
  int mismatched = 0;
  int n = 0;
  bit valid = 0;
  logic [15:0] m_sh, m_pend;
  logic [3:0]  m_shdp, m_pdp;
  bit          m_pnd;
  logic [3:0]  e_com;
  logic [7:0]  e_data;
  logic        e_tick;
  fnd_scan_driver #(.SCAN_DIV(16), .BLANK_CYC(3)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .fnd_com(fnd_com), .fnd_data(fnd_data), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0111111; 4'h1: return 7'b0000110; 4'h2: return 7'b1011011; 4'h3: return 7'b1001111;
      4'h4: return 7'b1100110; 4'h5: return 7'b1101101; 4'h6: return 7'b1111101; 4'h7: return 7'b0000111;
      4'h8: return 7'b1111111; 4'h9: return 7'b1101111; 4'hA: return 7'b1110111; 4'hB: return 7'b1111100;
      4'hC: return 7'b0111001; 4'hD: return 7'b1011110; 4'hE: return 7'b1111001; default: return 7'b1110001;
    endcase
  endfunction
  function automatic logic [7:0] digit_pins(input logic [15:0] v, input logic [3:0] dp, input int k);
    logic [3:0] d;
    bit dark;
    d = v[k*4 +: 4];
    dark = 0;
`ifdef FND_LZB_EN
    dark = k > 0 && (v >> (k*4)) == 16'd0 && !dp[k];
`endif
    return dark ? 8'hFF : ~{dp[k], seg7(d)};
  endfunction
  // model: n = clock edges since reset release; 16-cycle slots, first 3 cycles dark, 64-cycle frames
  always @(posedge clk) begin
    if (!rst) begin
      valid = 1;
      n = 0;
      m_sh = '0; m_shdp = '0; m_pend = '0; m_pdp = '0; m_pnd = 0;
      e_com = 4'hF; e_data = 8'hFF; e_tick = 0;
    end else begin
      n = n + 1;
      e_tick = (n % 64) == 0;
      if ((n - 1) % 16 >= 3) begin
        e_com = ~(4'b0001 << (((n - 1) / 16) % 4));
        e_data = digit_pins(m_sh, m_shdp, ((n - 1) / 16) % 4);
      end else begin
        e_com = 4'hF;
        e_data = 8'hFF;
      end
      if (e_tick && m_pnd) begin
        m_sh = m_pend; m_shdp = m_pdp; m_pnd = 0;
      end
      if (load) begin
        m_pend = digits_in; m_pdp = dp_in; m_pnd = 1;
      end
    end
  end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at n=%0d: got %h expected %h", nm, n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (valid) begin
      chk("com", {4'h0, fnd_com}, {4'h0, e_com});
      chk("data", fnd_data, e_data);
      chk("tick", {7'h0, frame_tick}, {7'h0, e_tick});
    end
  end
  task automatic wait_n(input int t);
    int k;
    k = 0;
    while (n != t && k < 2000) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (n != t) begin
      mismatched++;
      $display("FAIL wait_n: got n=%0d expected %0d", n, t);
    end
  endtask
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input int at);
    wait_n(at - 1);
    digits_in = v;
    dp_in = d;
    load = 1;
    @(negedge clk);
    load = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("lit_rst_com", {4'h0, fnd_com}, 8'h0F);
    chk("lit_rst_data", fnd_data, 8'hFF);
    rst = 1;
    wait_n(8);
    chk("lit_middrive_com", {4'h0, fnd_com}, 8'h0E);
    rst = 0;
    @(negedge clk);
    chk("lit_abort_com", {4'h0, fnd_com}, 8'h0F);
    chk("lit_abort_data", fnd_data, 8'hFF);
    chk("lit_abort_tick", {7'h0, frame_tick}, 8'h00);
    repeat (4) @(negedge clk);
    rst = 1;
    do_load(16'h1234, 4'b0000, 1);
    wait_n(3);
    chk("lit_first_blank", {4'h0, fnd_com}, 8'h0F);
    wait_n(4);
    chk("lit_first_com", {4'h0, fnd_com}, 8'h0E);
    chk("lit_first_data", fnd_data, 8'hC0);
    wait_n(64);
    chk("lit_tick", {7'h0, frame_tick}, 8'h01);
    wait_n(68);
    chk("lit_d0_4", fnd_data, 8'h99);
    wait_n(84);
    chk("lit_d1_com", {4'h0, fnd_com}, 8'h0D);
    chk("lit_d1_3", fnd_data, 8'hB0);
    do_load(16'h5678, 4'b0000, 85);
    wait_n(100);
    chk("lit_notear_d2", fnd_data, 8'hA4);
    wait_n(116);
    chk("lit_notear_d3", fnd_data, 8'hF9);
    wait_n(128);
    chk("lit_swap_tick", {7'h0, frame_tick}, 8'h01);
    wait_n(132);
    chk("lit_swap_d0_8", fnd_data, 8'h80);
    do_load(16'h1111, 4'b0000, 165);
    do_load(16'h2222, 4'b0000, 192);
    wait_n(196);
    chk("lit_coll_a", fnd_data, 8'hF9);
    wait_n(260);
    chk("lit_coll_b", fnd_data, 8'hA4);
    wait_n(324);
    chk("lit_coll_b_hold", fnd_data, 8'hA4);
    do_load(16'hF00C, 4'b0001, 330);
    wait_n(388);
    chk("lit_hex_c_dp", fnd_data, 8'h46);
    wait_n(436);
    chk("lit_hex_f", fnd_data, 8'h8E);
    do_load(16'h0042, 4'b0000, 440);
    wait_n(452);
    chk("lit_42_d0", fnd_data, 8'hA4);
    wait_n(484);
    chk("lit_42_d2_com", {4'h0, fnd_com}, 8'h0B);
`ifdef FND_LZB_EN
    chk("lit_42_d2", fnd_data, 8'hFF);
`else
    chk("lit_42_d2", fnd_data, 8'hC0);
`endif
    do_load(16'h0000, 4'b0100, 500);
    wait_n(548);
    chk("lit_dp_d2", fnd_data, 8'h40);
    wait_n(564);
`ifdef FND_LZB_EN
    chk("lit_dp_d3", fnd_data, 8'hFF);
`else
    chk("lit_dp_d3", fnd_data, 8'hC0);
`endif
    do_load(16'h0000, 4'b0000, 570);
    wait_n(580);
    chk("lit_zero_d0", fnd_data, 8'hC0);
    wait_n(596);
`ifdef FND_LZB_EN
    chk("lit_zero_d1", fnd_data, 8'hFF);
`else
    chk("lit_zero_d1", fnd_data, 8'hC0);
`endif
    wait_n(660);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
